// File: rtl/mips_bus_pkg.sv
// Shared types and default widths for the two-master MIPS memory bus arbiter.
package mips_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RDWAIT
  } arb_state_t;

  typedef logic master_id_t;

  localparam master_id_t MID_INSTR = 1'b0;
  localparam master_id_t MID_DATA  = 1'b1;

endpackage

// File: rtl/mips_bus_arbiter_if.sv
// One Avalon-style bus link: the master modport drives the command, the slave modport answers.
interface mips_bus_arbiter_if #(
  parameter int ADDR_W = mips_bus_pkg::ADDR_W,
  parameter int DATA_W = mips_bus_pkg::DATA_W
);

  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );

endinterface

// File: rtl/mips_bus_arb_pick.sv
// Combinational winner select between fetch (m0) and data (m1).
// MIPS_BUS_ARB_ROUND_ROBIN_EN selects alternating priority; default is m1-over-m0 fixed priority.
module mips_bus_arb_pick
  import mips_bus_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  master_id_t last,
  output master_id_t winner
);

`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
  always_comb begin
    if (req0 && req1) begin
      winner = ~last;
    end else if (req1) begin
      winner = MID_DATA;
    end else begin
      winner = MID_INSTR;
    end
  end
`else
  logic unused_pick;
  assign unused_pick = req0 ^ last;
  assign winner      = req1 ? MID_DATA : MID_INSTR;
`endif

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master arbiter sequencing one transaction at a time onto a waitrequest-stalled memory slave.
// Arbitration policy is set by MIPS_BUS_ARB_ROUND_ROBIN_EN (see mips_bus_arb_pick).
module mips_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  mips_bus_arbiter_if.slave   m0,
  mips_bus_arbiter_if.slave   m1,
  mips_bus_arbiter_if.master  s,
  output logic                grant
);

  import mips_bus_pkg::*;

  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  arb_state_t          state;
  logic                op_write;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rdata0;
  logic [DATA_W-1:0]   rdata1;

  logic                req0;
  logic                req1;
  master_id_t          winner;
  logic                wr_done;
  logic                rd_done;

  logic [ADDR_W-1:0]   sel_address;
  logic                sel_write;
  logic [DATA_W-1:0]   sel_writedata;
  logic [DATA_W/8-1:0] sel_byteenable;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  mips_bus_arb_pick u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (grant),
    .winner (winner)
  );

  assign sel_address    = (winner == MID_DATA) ? m1.address    : m0.address;
  assign sel_write      = (winner == MID_DATA) ? m1.write      : m0.write;
  assign sel_writedata  = (winner == MID_DATA) ? m1.writedata  : m0.writedata;
  assign sel_byteenable = (winner == MID_DATA) ? m1.byteenable : m0.byteenable;

  // Completions are decided in the same cycle the slave accepts or returns data.
  assign wr_done = (state == CMD) && op_write && !s.waitrequest;
  assign rd_done = (state == RDWAIT) && (cnt == CNT_W'(1));

  assign m0.waitrequest = !((wr_done || rd_done) && (grant == MID_INSTR));
  assign m1.waitrequest = !((wr_done || rd_done) && (grant == MID_DATA));
  assign m0.readdata    = (rd_done && grant == MID_INSTR) ? s.readdata : rdata0;
  assign m1.readdata    = (rd_done && grant == MID_DATA)  ? s.readdata : rdata1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      op_write     <= 1'b0;
      cnt          <= '0;
      grant        <= MID_INSTR;
      rdata0       <= '0;
      rdata1       <= '0;
      s.address    <= '0;
      s.read       <= 1'b0;
      s.write      <= 1'b0;
      s.writedata  <= '0;
      s.byteenable <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant        <= winner;
            op_write     <= sel_write;
            s.address    <= sel_address;
            s.writedata  <= sel_writedata;
            s.byteenable <= sel_byteenable;
            s.write      <= sel_write;
            s.read       <= !sel_write;
            state        <= CMD;
          end
        end
        CMD: begin
          if (!s.waitrequest) begin
            s.read  <= 1'b0;
            s.write <= 1'b0;
            if (op_write) begin
              state <= IDLE;
            end else begin
              cnt   <= CNT_W'(READ_LATENCY);
              state <= RDWAIT;
            end
          end
        end
        RDWAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            if (grant == MID_DATA) begin
              rdata1 <= s.readdata;
            end else begin
              rdata0 <= s.readdata;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter (default fixed-priority build), with READ_LATENCY 1 and 3 instances.
module tb_mips_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic s_wait;
  logic grant;
  logic grant3;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mips_bus_arbiter_if bus0 ();
  mips_bus_arbiter_if bus1 ();
  mips_bus_arbiter_if sbus ();
  mips_bus_arbiter_if b3m0 ();
  mips_bus_arbiter_if b3m1 ();
  mips_bus_arbiter_if sb3 ();

  mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (bus0),
    .m1    (bus1),
    .s     (sbus),
    .grant (grant)
  );

  mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .m0    (b3m0),
    .m1    (b3m1),
    .s     (sb3),
    .grant (grant3)
  );

  // Slave memory for the latency-1 instance; readdata is zero except in the valid cycle.
  logic [31:0] mem [64];
  logic [31:0] rd1;

  assign sbus.waitrequest = s_wait;
  assign sbus.readdata    = rd1;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h3C08BFC0;
      mem[1] <= 32'hAAAA5555;
      mem[2] <= 32'h8FBF0010;
    end else if (sbus.write && !sbus.waitrequest) begin
      for (int b = 0; b < 4; b++)
        if (sbus.byteenable[b]) mem[sbus.address[7:2]][8*b +: 8] <= sbus.writedata[8*b +: 8];
    end
    rd1 <= (sbus.read && !sbus.waitrequest) ? mem[sbus.address[7:2]] : 32'h0;
  end

  // Latency-3 slave: fixed contents, three-stage data pipeline.
  function automatic logic [31:0] rom3(input logic [31:0] a);
    return (a == 32'h10) ? 32'h0BADF00D : (a ^ 32'h5A5A5A5A);
  endfunction

  logic [31:0] p3 [3];

  assign sb3.waitrequest = 1'b0;
  assign sb3.readdata    = p3[2];

  always @(posedge clk) begin
    p3[0] <= (sb3.read && !sb3.waitrequest) ? rom3(sb3.address) : 32'h0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  initial begin
    reset = 1'b1;
    s_wait = 1'b0;
    bus0.address = '0; bus0.read = 0; bus0.write = 0; bus0.writedata = '0; bus0.byteenable = '0;
    bus1.address = '0; bus1.read = 0; bus1.write = 0; bus1.writedata = '0; bus1.byteenable = '0;
    b3m0.address = '0; b3m0.read = 0; b3m0.write = 0; b3m0.writedata = '0; b3m0.byteenable = '0;
    b3m1.address = '0; b3m1.read = 0; b3m1.write = 0; b3m1.writedata = '0; b3m1.byteenable = '0;

    repeat (2) @(posedge clk);
    #1;
    smp();
    check_output("rst_s_read", sbus.read, 0);
    check_output("rst_s_write", sbus.write, 0);
    check_output("rst_s_address", sbus.address, 0);
    check_output("rst_m0_wait", bus0.waitrequest, 1);
    check_output("rst_m1_wait", bus1.waitrequest, 1);
    check_output("rst_m0_rdata", bus0.readdata, 0);
    check_output("rst_grant", grant, 0);
    cyc();
    reset = 1'b0;

    $display("[TB] m0 read, latency 1");
    cyc();
    bus0.address = 32'hBFC00000; bus0.read = 1;
    smp();
    check_output("rd0_t0_s_read", sbus.read, 0);
    check_output("rd0_t0_wait", bus0.waitrequest, 1);
    cyc(); smp();
    check_output("rd0_t1_s_read", sbus.read, 1);
    check_output("rd0_t1_s_addr", sbus.address, 32'hBFC00000);
    check_output("rd0_t1_wait", bus0.waitrequest, 1);
    check_output("rd0_t1_grant", grant, 0);
    cyc(); smp();
    check_output("rd0_t2_s_read", sbus.read, 0);
    check_output("rd0_t2_wait", bus0.waitrequest, 0);
    check_output("rd0_t2_rdata", bus0.readdata, 32'h3C08BFC0);
    cyc();
    bus0.read = 0;
    smp();
    check_output("rd0_t3_wait", bus0.waitrequest, 1);
    check_output("rd0_t3_rdata_hold", bus0.readdata, 32'h3C08BFC0);

    $display("[TB] m1 write");
    cyc();
    bus1.address = 32'hBFC0002C; bus1.writedata = 32'h2; bus1.byteenable = 4'hF; bus1.write = 1;
    smp();
    check_output("wr1_t0_s_write", sbus.write, 0);
    check_output("wr1_t0_wait", bus1.waitrequest, 1);
    cyc(); smp();
    check_output("wr1_t1_s_write", sbus.write, 1);
    check_output("wr1_t1_s_addr", sbus.address, 32'hBFC0002C);
    check_output("wr1_t1_s_wdata", sbus.writedata, 32'h2);
    check_output("wr1_t1_wait", bus1.waitrequest, 0);
    check_output("wr1_t1_grant", grant, 1);
    cyc();
    bus1.write = 0;
    smp();
    check_output("wr1_t2_s_write", sbus.write, 0);
    check_output("wr1_t2_wait", bus1.waitrequest, 1);
    check_output("wr1_mem11", mem[11], 32'h2);

    $display("[TB] contended reads");
    cyc();
    bus0.address = 32'hBFC00008; bus0.read = 1;
    bus1.address = 32'hBFC00004; bus1.read = 1;
    smp();
    cyc(); smp();
    check_output("both_t1_grant", grant, 1);
    check_output("both_t1_s_addr", sbus.address, 32'hBFC00004);
    check_output("both_t1_s_read", sbus.read, 1);
    cyc(); smp();
    check_output("both_t2_m1_wait", bus1.waitrequest, 0);
    check_output("both_t2_m1_rdata", bus1.readdata, 32'hAAAA5555);
    check_output("both_t2_m0_wait", bus0.waitrequest, 1);
    check_output("both_t2_m0_rdata_hold", bus0.readdata, 32'h3C08BFC0);
    cyc();
    bus1.read = 0;
    smp();
    check_output("both_t3_m0_wait", bus0.waitrequest, 1);
    check_output("both_t3_m1_wait", bus1.waitrequest, 1);
    cyc(); smp();
    check_output("both_t4_grant", grant, 0);
    check_output("both_t4_s_addr", sbus.address, 32'hBFC00008);
    check_output("both_t4_m0_wait", bus0.waitrequest, 1);
    cyc(); smp();
    check_output("both_t5_m0_wait", bus0.waitrequest, 0);
    check_output("both_t5_m0_rdata", bus0.readdata, 32'h8FBF0010);
    check_output("both_t5_m1_rdata_hold", bus1.readdata, 32'hAAAA5555);
    cyc();
    bus0.read = 0;
    smp();
    check_output("both_t6_m0_wait", bus0.waitrequest, 1);

    $display("[TB] stalled write");
    cyc();
    s_wait = 1;
    bus1.address = 32'hBFC00030; bus1.writedata = 32'hDEADBEEF; bus1.byteenable = 4'h3; bus1.write = 1;
    smp();
    for (int i = 0; i < 5; i++) begin
      cyc(); smp();
      check_output("stall_s_write", sbus.write, 1);
      check_output("stall_s_addr", sbus.address, 32'hBFC00030);
      check_output("stall_m1_wait", bus1.waitrequest, 1);
    end
    cyc();
    s_wait = 0;
    smp();
    check_output("stall_acc_s_write", sbus.write, 1);
    check_output("stall_acc_m1_wait", bus1.waitrequest, 0);
    cyc();
    bus1.write = 0;
    smp();
    check_output("stall_after_s_write", sbus.write, 0);
    check_output("stall_after_m1_wait", bus1.waitrequest, 1);
    check_output("stall_mem12_lanes", mem[12], 32'h0000BEEF);

    $display("[TB] m0 read, latency 3");
    cyc();
    b3m0.address = 32'h10; b3m0.read = 1;
    smp();
    cyc(); smp();
    check_output("l3_t1_s_read", sb3.read, 1);
    check_output("l3_t1_wait", b3m0.waitrequest, 1);
    for (int i = 2; i < 4; i++) begin
      cyc(); smp();
      check_output("l3_rdwait_s_read", sb3.read, 0);
      check_output("l3_rdwait_s_write", sb3.write, 0);
      check_output("l3_rdwait_wait", b3m0.waitrequest, 1);
    end
    cyc(); smp();
    check_output("l3_t4_wait", b3m0.waitrequest, 0);
    check_output("l3_t4_rdata", b3m0.readdata, 32'h0BADF00D);
    cyc();
    b3m0.read = 0;
    smp();
    check_output("l3_t5_wait", b3m0.waitrequest, 1);
    check_output("l3_t5_rdata_hold", b3m0.readdata, 32'h0BADF00D);

    $display("[TB] reset during RDWAIT");
    cyc();
    b3m0.address = 32'h14; b3m0.read = 1;
    smp();
    cyc(); smp();
    check_output("rr_t1_s_read", sb3.read, 1);
    cyc();
    reset = 1;
    smp();
    check_output("rr_t2_wait", b3m0.waitrequest, 1);
    cyc();
    reset = 0;
    b3m0.read = 0;
    smp();
    check_output("rr_t3_s_read", sb3.read, 0);
    check_output("rr_t3_m0_wait", b3m0.waitrequest, 1);
    check_output("rr_t3_m1_wait", b3m1.waitrequest, 1);
    check_output("rr_t3_rdata", b3m0.readdata, 0);
    check_output("rr_t3_grant", grant3, 0);
    cyc(); smp();
    check_output("rr_t4_no_pulse", b3m0.waitrequest, 1);
    check_output("rr_t4_rdata", b3m0.readdata, 0);
    cyc();
    b3m0.address = 32'h14; b3m0.read = 1;
    smp();
    for (int i = 1; i < 4; i++) begin
      cyc(); smp();
      check_output("rr_new_wait_hi", b3m0.waitrequest, 1);
    end
    cyc(); smp();
    check_output("rr_new_wait_lo", b3m0.waitrequest, 0);
    check_output("rr_new_rdata", b3m0.readdata, 32'h5A5A5A4E);
    cyc();
    b3m0.read = 0;
    smp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Shares the single Avalon-style memory bus of the test harness between two masters: m0 = instruction fetch, m1 = data load/store.
- Masters see a waitrequest-stalled bus. The slave memory has fixed registered read latency and may assert waitrequest.
- Sits between the CPU's fetch/data units and the memory slave. It sequences one transaction at a time.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1, cycles from slave read acceptance to valid s_readdata; legal values ≥1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- m0_address, m1_address  in  ADDR_W  master byte address.
- m0_read, m1_read  in  1  read request.
- m0_write, m1_write  in  1  write request.
- m0_writedata, m1_writedata  in  DATA_W  write data.
- m0_byteenable, m1_byteenable  in  DATA_W/8  byte lanes.
- m0_waitrequest, m1_waitrequest  out  1  stall; low exactly on the completion cycle.
- m0_readdata, m1_readdata  out  DATA_W  read data, valid on the completion cycle.
- s_address  out  ADDR_W  slave address.
- s_read, s_write  out  1  slave strobes.
- s_writedata  out  DATA_W  slave write data.
- s_byteenable  out  DATA_W/8  slave byte lanes.
- s_waitrequest  in  1  slave stall.
- s_readdata  in  DATA_W  slave read data.
- grant  out  1  id of the master owning the current or last transaction.

Behaviour:
- Reset values:
  - s_read=0, s_write=0.
  - s_address, s_writedata, s_byteenable = 0.
  - m0_waitrequest=1, m1_waitrequest=1.
  - m*_readdata=0.
  - grant=0; priority pointer set so m1 wins first.
  - state=IDLE; latency counter=0.
- Master contract: a request (read|write) is held with stable fields while waitrequest is high. Both read and write asserted together → treated as a write.
- IDLE:
  - If any request is present, pick a winner and latch its address/writedata/byteenable/op into registers.
  - grant <= winner; go to CMD. Otherwise stay in IDLE.
- CMD:
  - s_read or s_write is driven from the latched command.
  - If s_waitrequest=1, stay in CMD with the command held.
  - Write accepted (s_waitrequest=0): winner's waitrequest=0 this cycle → IDLE.
  - Read accepted: drop the strobe → RDWAIT with counter=READ_LATENCY.
- RDWAIT:
  - s_read=0, s_write=0; counter decrements each cycle.
  - When counter reaches 1, in that cycle: winner's m_readdata = s_readdata, winner's waitrequest=0 → IDLE.
- Latency:
  - Uncontended write with s_waitrequest=0: request seen at cycle t, completes at t+1.
  - Uncontended read: completes at t+1+READ_LATENCY.
  - A new arbitration occurs no earlier than the cycle after completion.
- Non-winning master: waitrequest stays 1 and its readdata holds its last value. Only the winner's outputs change.
- Arbitration, both requesting in IDLE: fixed priority, m1 (data) wins (see Optional Feature).
- s_waitrequest=1 indefinitely: no timeout; the arbiter stays in CMD.
- Reset mid-transaction: next cycle is IDLE with all reset values. An outstanding read's data is discarded and no completion pulse is issued.
- Requests withdrawn in CMD/RDWAIT: ignored. The latched command completes normally.

Optional Feature:
- Macro: MIPS_BUS_ARB_ROUND_ROBIN_EN.
- Defined: when both masters request, the master not granted last wins, i.e. they alternate. A single requester always wins. The pointer updates on each grant.
- Undefined: fixed priority, m1 over m0; m0 may starve under continuous m1 traffic.

Decomposition:
- Package mips_bus_pkg:
  - arb_state_t enum {IDLE, CMD, RDWAIT}.
  - master_id_t (1 bit) with constants MID_INSTR=0, MID_DATA=1.
  - Default width constants ADDR_W/DATA_W.
- One natural sub-module: mips_bus_arb_pick, a combinational winner select (fixed/RR) from req0, req1 and the last-grant pointer.
- The latency counter and FSM stay in the top.

Test Plan:
- m0 read 0xBFC00000, memory word 0x3C08BFC0, READ_LATENCY=1, s_waitrequest=0 → s_read high one cycle at t+1; m0_waitrequest low at t+2 with m0_readdata=0x3C08BFC0; grant=0.
- m1 write 0xBFC0002C, data 0x00000002, byteenable 0xF → s_write for exactly one cycle; m1_waitrequest low at t+1; memory word 11 = 0x00000002.
- Both masters read at t, fixed priority → m1 completes first; m0 completes 3 cycles later. With MIPS_BUS_ARB_ROUND_ROBIN_EN and repeated requests, the sequence is m1, m0, m1, m0.
- s_waitrequest held high for 5 cycles during a write → s_write and s_address stable for all 5 cycles; m1_waitrequest low only on the acceptance cycle.
- READ_LATENCY=3, m0 read → completion at t+4; strobes low during RDWAIT.
- reset asserted during RDWAIT → next cycle s_read=0, both waitrequests=1, state IDLE, no completion pulse; a subsequent m0 read completes normally.
